instr_loader: RTL and testbench

Upstream program loader for the instruction memory. Receives a byte stream from the debug UART receiver and packs each group of four bytes into one big-endian 32-bit instruction. Writes each word into the instruction memory's write port at consecutive word addresses starting from 0. Stops on the halt instruction or when memory is full, then reports completion to the debug unit.

---
 rtl/instr_loader.sv | 136 +++++++++++++
 tb/tb_instr_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Packs a byte stream into big-endian words and writes them to instruction memory.
// Define LOADER_HALT_DETECT_EN to end a load on HALT_WORD as well as on a full memory.
module instr_loader #(
  parameter int NBITS = 8,
  parameter int INST_BITS = 32,
  parameter int CELLS = 256,
  parameter logic [INST_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NBITS-1:0]     i_rx_data,
  input  logic                 i_rx_valid,
  output logic [INST_BITS-1:0] o_addr_wr,
  output logic [INST_BITS-1:0] o_data,
  output logic                 o_wr_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overrun,
  output logic [INST_BITS-1:0] o_word_count
);

  localparam int MAX_WORDS = CELLS / 4;

`ifdef LOADER_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [INST_BITS-1:0] data_q, data_d;
  logic [INST_BITS-1:0] addr_q, addr_d;
  logic [INST_BITS-1:0] cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 wr_en_q, wr_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [INST_BITS-1:0] cnt_inc;
  logic                 halt_hit;
  logic                 last_word;

  assign cnt_inc   = cnt_q + INST_BITS'(1);
  assign halt_hit  = HALT_EN && (data_q == HALT_WORD);
  assign last_word = halt_hit || (cnt_inc == INST_BITS'(MAX_WORDS));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          idx_d   = 2'd0;
          addr_d  = '0;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (i_rx_valid) begin
          unique case (idx_q)
            2'd0: data_d[4*NBITS-1 -: NBITS] = i_rx_data;
            2'd1: data_d[3*NBITS-1 -: NBITS] = i_rx_data;
            2'd2: data_d[2*NBITS-1 -: NBITS] = i_rx_data;
            2'd3: data_d[NBITS-1 -: NBITS]   = i_rx_data;
            default: ;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + INST_BITS'(4);
        cnt_d   = cnt_inc;
        // The UART cannot be stalled, so a byte landing here is lost.
        if (i_rx_valid) begin
          ovr_d = 1'b1;
        end
        state_d = last_word ? S_DONE : S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
    wr_en_d = (state_d == S_WRITE);
    busy_d  = (state_d == S_RECV) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      data_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_addr_wr    = addr_q;
  assign o_data       = data_q;
  assign o_wr_en      = wr_en_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_overrun    = ovr_q;
  assign o_word_count = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_instr_loader;

  localparam int CELLS = 16;
  localparam int MAXW = CELLS / 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

`ifdef LOADER_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rxv = 1'b0;
  logic [31:0] addr, data, wcnt;
  logic        wr_en, busy, done, ovr;

  instr_loader #(
    .NBITS(8),
    .INST_BITS(32),
    .CELLS(CELLS),
    .HALT_WORD(HALT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_rx_data(rxd),
    .i_rx_valid(rxv),
    .o_addr_wr(addr),
    .o_data(data),
    .o_wr_en(wr_en),
    .o_busy(busy),
    .o_done(done),
    .o_overrun(ovr),
    .o_word_count(wcnt)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 receiving, 2 writing, 3 done.
  int          m_mode = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_word = '0;
  int          m_count = 0;
  bit          m_over = 0;
  bit          armed = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 0;
        m_bytes.delete();
        m_count = 0;
        m_over = 0;
        armed = 1;
      end else if (m_mode == 0 || m_mode == 3) begin
        if (start) begin
          m_mode = 1;
          m_bytes.delete();
          m_count = 0;
          m_over = 0;
        end
      end else if (m_mode == 1) begin
        if (rxv) begin
          m_bytes.push_back(rxd);
          if (m_bytes.size() == 4) begin
            m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            m_bytes.delete();
            m_mode = 2;
          end
        end
      end else begin
        m_count++;
        if (rxv) m_over = 1;
        m_mode = (m_count == MAXW || (HALT_EN && m_word == HALT)) ? 3 : 1;
      end
    end
  end

  logic [63:0] wlog[$];

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("wr_en", 64'(wr_en), 64'(m_mode == 2));
        chk("busy", 64'(busy), 64'(m_mode == 1 || m_mode == 2));
        chk("done", 64'(done), 64'(m_mode == 3));
        chk("overrun", 64'(ovr), 64'(m_over));
        chk("count", 64'(wcnt), 64'(m_count));
        chk("addr", 64'(addr), 64'(4 * m_count));
        if (m_mode == 2) chk("data", 64'(data), 64'(m_word));
        if (wr_en) wlog.push_back({addr, data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxv = 1'b1;
    rxd = b;
    tick();
    rxv = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    send_byte(8'h55);
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(wcnt), 64'(0));
    chk("rst_nowrite", 64'(wlog.size()), 64'(0));

    wlog.delete();
    pulse_start();
    send_word(32'h2001_0005);
    chk("single_n", 64'(wlog.size()), 64'(1));
    chk("single_w", wlog[0], {32'h0, 32'h2001_0005});
    chk("single_cnt", 64'(wcnt), 64'(1));
    chk("single_addr", 64'(addr), 64'(4));

    send_byte(8'h01);
    send_byte(8'h02);
    do_reset();
    wlog.delete();
    pulse_start();
    send_word(32'hAABB_CCDD);
    chk("midrst_n", 64'(wlog.size()), 64'(1));
    chk("midrst_w", wlog[0], {32'h0, 32'hAABB_CCDD});

    do_reset();
    wlog.delete();
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    tick();
    tick();
    chk("ovr_flag", 64'(ovr), 64'(1));
    chk("ovr_n", 64'(wlog.size()), 64'(2));
    chk("ovr_w0", wlog[0], {32'h0, 32'h1122_3344});
    chk("ovr_w1", wlog[1], {32'h4, 32'h6677_8899});

    do_reset();
    wlog.delete();
    pulse_start();
    send_word(32'h2001_0005);
    send_word(32'h0000_0000);
    send_word(32'hFFFF_FFFF);
    chk("halt_n", 64'(wlog.size()), 64'(3));
    chk("halt_a8", wlog[2], {32'h8, 32'hFFFF_FFFF});
    chk("halt_cnt", 64'(wcnt), 64'(3));
    chk("halt_done", 64'(done), 64'(HALT_EN));

    do_reset();
    wlog.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(32'hFFFF_FFFF);
    send_word(32'h1234_5678);
`ifdef LOADER_HALT_DETECT_EN
    chk("full_n", 64'(wlog.size()), 64'(1));
    chk("full_cnt", 64'(wcnt), 64'(1));
`else
    chk("full_n", 64'(wlog.size()), 64'(4));
    chk("full_a12", wlog[3], {32'hC, 32'hFFFF_FFFF});
    chk("full_cnt", 64'(wcnt), 64'(4));
`endif
    chk("full_done", 64'(done), 64'(1));

    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 99) < 6);
      rxv = ($urandom_range(0, 99) < 65);
      rxd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    rxv = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
